// File: rtl/bram_sequencer.sv
// Walks NUM_WORDS words of a BRAM through a valid/ready port, optionally writing a
// SEED-based pattern first, and shows each word read on the LEDs for WAIT_TICKS cycles.
module bram_sequencer #(
  parameter int          NUM_WORDS  = 2,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          WAIT_TICKS = 25_000_000,
  parameter int          LED_WIDTH  = 8,
  parameter int          MODE       = 0,
  parameter logic [31:0] SEED       = 32'h0000_0001,
  parameter int          LOOP       = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [31:0]          err_addr,
  output logic [LED_WIDTH-1:0] led,
  output logic                 mem_valid,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_wstrb,
  input  logic                 mem_ready,
  input  logic [31:0]          mem_rdata
);

  localparam int IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int TICK_W = (WAIT_TICKS > 1) ? $clog2(WAIT_TICKS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_WORDS - 1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(WAIT_TICKS - 1);

  typedef enum logic [2:0] {IDLE, WRITE, READ, SHOW, NEXT} state_t;

  localparam state_t RESTART = (MODE == 1) ? WRITE : READ;

  state_t            state, state_next;
  logic [IDX_W-1:0]  idx;
  logic [TICK_W-1:0] tick;
  logic              xfer, last_word, last_tick;
  logic [31:0]       word_addr, word_pattern;

  assign xfer         = mem_valid & mem_ready;
  assign last_word    = (idx == LAST_IDX);
  assign last_tick    = (tick == LAST_TICK);
  assign word_addr    = BASE_ADDR + (32'(idx) << 2);
  assign word_pattern = SEED + 32'(idx);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = start ? RESTART : IDLE;
      WRITE:   state_next = (xfer && last_word) ? READ : WRITE;
      READ:    state_next = xfer ? SHOW : READ;
      SHOW:    state_next = last_tick ? NEXT : SHOW;
      NEXT: begin
        if (!last_word)     state_next = READ;
        else if (LOOP == 1) state_next = RESTART;
        else                state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Request bus is registered; a request is raised only from a valid-low cycle,
  // which guarantees the idle gap between back-to-back transfers.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_addr  <= 32'h0;
      led       <= '0;
      mem_valid <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_wstrb <= 4'h0;
      idx       <= '0;
      tick      <= '0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state == NEXT) && last_word;
      case (state)
        IDLE: begin
          idx  <= '0;
          tick <= '0;
          if (start) begin
            error    <= 1'b0;
            err_addr <= 32'h0;
          end
        end
        WRITE, READ: begin
          if (xfer) begin
            mem_valid <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
            mem_wstrb <= 4'h0;
            if (state == WRITE) begin
              idx <= last_word ? IDX_W'(0) : idx + IDX_W'(1);
            end else begin
              led  <= mem_rdata[LED_WIDTH-1:0];
              tick <= '0;
              if ((MODE == 1) && (mem_rdata != word_pattern)) begin
                error <= 1'b1;
                if (!error) err_addr <= mem_addr;
              end
            end
          end else if (!mem_valid) begin
            mem_valid <= 1'b1;
            mem_addr  <= word_addr;
            mem_wdata <= (state == WRITE) ? word_pattern : 32'h0;
            mem_wstrb <= (state == WRITE) ? 4'hF : 4'h0;
          end
        end
        SHOW:    tick <= last_tick ? TICK_W'(0) : tick + TICK_W'(1);
        NEXT:    idx  <= last_word ? IDX_W'(0) : idx + IDX_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_sequencer.sv
// Directed bench: a write/verify instance (MODE=1, LOOP=0) and a looping
// read-display instance (MODE=0, LOOP=1), each with a small behavioural BRAM.
module tb_bram_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: MODE=1, 4 words, SEED=0xA5, LOOP=0
  logic        start_a, busy_a, done_a, error_a, valid_a, ready_a;
  logic [31:0] err_addr_a, addr_a, wdata_a, rdata_a;
  logic [7:0]  led_a;
  logic [3:0]  wstrb_a, corrupt_a;
  logic        auto_a, man_ready, mr_a;
  int          cnt_a, lat_a;
  logic [31:0] mem_a [4];

  // Instance B: MODE=0, 2 words, LOOP=1
  logic        start_b, busy_b, done_b, error_b, valid_b, mr_b;
  logic [31:0] err_addr_b, addr_b, wdata_b, rdata_b;
  logic [7:0]  led_b;
  logic [3:0]  wstrb_b;

  int n_cmp = 0, n_fail = 0;
  int extra, nd, c1, c2, c3, nlog, viol;
  logic [7:0] prev, lg [3];

  bram_sequencer #(.NUM_WORDS(4), .BASE_ADDR(32'h0), .WAIT_TICKS(3), .LED_WIDTH(8),
                   .MODE(1), .SEED(32'hA5), .LOOP(0)) dut_a (
    .clk(clk), .reset(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .error(error_a), .err_addr(err_addr_a), .led(led_a), .mem_valid(valid_a),
    .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_wstrb(wstrb_a),
    .mem_ready(ready_a), .mem_rdata(rdata_a));

  bram_sequencer #(.NUM_WORDS(2), .BASE_ADDR(32'h0), .WAIT_TICKS(3), .LED_WIDTH(8),
                   .MODE(0), .SEED(32'h1), .LOOP(1)) dut_b (
    .clk(clk), .reset(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .error(error_b), .err_addr(err_addr_b), .led(led_b), .mem_valid(valid_b),
    .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_wstrb(wstrb_b),
    .mem_ready(mr_b), .mem_rdata(rdata_b));

  assign ready_a = auto_a ? mr_a : man_ready;
  assign rdata_a = mem_a[addr_a[3:2]] ^ (corrupt_a[addr_a[3:2]] ? 32'h1000_0000 : 32'h0);
  assign rdata_b = {24'h0, addr_b[2] ? 8'h42 : 8'h81};

  // Model A: ready after lat_a+2 valid cycles in auto mode; writes on handshake
  always @(posedge clk) begin
    if (rst) begin
      mr_a  <= 1'b0;
      cnt_a <= 0;
    end else if (valid_a && ready_a) begin
      mr_a  <= 1'b0;
      cnt_a <= 0;
      if (wstrb_a == 4'hF) mem_a[addr_a[3:2]] <= wdata_a;
    end else if (valid_a && auto_a) begin
      if (cnt_a == lat_a) mr_a <= 1'b1;
      else cnt_a <= cnt_a + 1;
    end
  end

  // Model B: ready in the second valid cycle
  always @(posedge clk) begin
    if (rst) mr_b <= 1'b0;
    else     mr_b <= valid_b && !mr_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_a(input string p);
    chk({p, "_busy"},  {31'h0, busy_a},  32'h0);
    chk({p, "_done"},  {31'h0, done_a},  32'h0);
    chk({p, "_error"}, {31'h0, error_a}, 32'h0);
    chk({p, "_erra"},  err_addr_a,       32'h0);
    chk({p, "_led"},   {24'h0, led_a},   32'h0);
    chk({p, "_valid"}, {31'h0, valid_a}, 32'h0);
    chk({p, "_addr"},  addr_a,           32'h0);
    chk({p, "_wdata"}, wdata_a,          32'h0);
    chk({p, "_wstrb"}, {28'h0, wstrb_a}, 32'h0);
  endtask

  task automatic pulse_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string tag);
    int k;
    for (k = 0; k < 400 && !done_a; k++) @(negedge clk);
    chk({tag, "_done_seen"}, {31'h0, done_a}, 32'h1);
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; auto_a = 1'b0; man_ready = 1'b0;
    lat_a = 1; corrupt_a = 4'h0;
    repeat (3) @(negedge clk);
    chk_reset_a("rst0");
    rst = 1'b0;
    @(negedge clk);

    // Long-latency write handshake driven by hand
    pulse_a();
    chk("start_busy", {31'h0, busy_a}, 32'h1);
    for (int k = 0; k < 10 && !valid_a; k++) @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      chk("hold_req", {valid_a, wstrb_a, addr_a[7:0], wdata_a[7:0]}, {1'b1, 4'hF, 8'h00, 8'hA5});
      if (c == 5) man_ready = 1'b1;
      @(negedge clk);
    end
    chk("drop_valid", {31'h0, valid_a}, 32'h0);
    @(negedge clk);
    man_ready = 1'b0;
    chk("next_req", {valid_a, addr_a[7:0], wdata_a[7:0]}, {1'b1, 8'h04, 8'hA6});
    auto_a = 1'b1;

    // Start during SHOW is ignored
    for (int k = 0; k < 300 && !(valid_a && ready_a && wstrb_a == 4'h0); k++) @(negedge clk);
    @(negedge clk);
    chk("led_w0", {24'h0, led_a}, 32'hA5);
    pulse_a();
    chk("show_led", {24'h0, led_a}, 32'hA5);
    chk("show_quiet", {valid_a, busy_a}, {1'b0, 1'b1});
    wait_done_a("p1");
    chk("p1_error", {31'h0, error_a}, 32'h0);
    chk("p1_led", {24'h0, led_a}, 32'hA8);
    @(negedge clk);
    chk("p1_idle", {done_a, busy_a}, 2'b00);
    extra = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done_a || busy_a) extra++;
    end
    chk("p1_stays_idle", extra, 32'h0);

    // Corrupted reads at 0x8 and 0xC
    corrupt_a = 4'b1100;
    pulse_a();
    wait_done_a("p2");
    chk("p2_error", {31'h0, error_a}, 32'h1);
    chk("p2_erra", err_addr_a, 32'h8);

    // Start from IDLE clears the sticky flag
    corrupt_a = 4'h0;
    pulse_a();
    chk("p3_clr", {error_a, err_addr_a[30:0]}, 32'h0);
    wait_done_a("p3");
    chk("p3_error", {31'h0, error_a}, 32'h0);

    // Reset mid-write, then a fresh pass
    pulse_a();
    for (int k = 0; k < 100 && !(valid_a && addr_a == 32'h4 && wstrb_a == 4'hF); k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_a("rst1");
    pulse_a();
    for (int k = 0; k < 10 && !valid_a; k++) @(negedge clk);
    chk("fresh_req", {valid_a, addr_a[7:0], wdata_a[7:0]}, {1'b1, 8'h00, 8'hA5});
    wait_done_a("p4");
    chk("p4_error", {31'h0, error_a}, 32'h0);

    // Looping read-display instance
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    nd = 0; c1 = 0; c2 = 0; c3 = 0; nlog = 0; viol = 0; prev = led_b;
    for (int k = 0; k < 120 && nd < 3; k++) begin
      @(negedge clk);
      if (valid_b && (wdata_b != 32'h0 || wstrb_b != 4'h0)) viol++;
      if (led_b !== prev) begin
        if (nlog < 3) lg[nlog] = led_b;
        nlog++;
        prev = led_b;
      end
      if (done_b) begin
        if (nd == 0) c1 = k;
        else if (nd == 1) c2 = k;
        else c3 = k;
        nd++;
      end
    end
    chk("b_dones", nd, 32'd3);
    chk("b_period1", c2 - c1, 32'd14);
    chk("b_period2", c3 - c2, 32'd14);
    chk("b_led0", {24'h0, lg[0]}, 32'h81);
    chk("b_led1", {24'h0, lg[1]}, 32'h42);
    chk("b_led2", {24'h0, lg[2]}, 32'h81);
    chk("b_read_bus", viol, 32'h0);
    chk("b_busy", {busy_b, error_b}, 2'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/bram_sequencer.md
BRAM_SEQUENCER -- requirements
Module: bram_sequencer

Interface
REQ-001 SHALL provide parameter NUM_WORDS, default 2, number of 32-bit words walked per pass (>=1).
REQ-002 SHALL provide parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0 (word-aligned).
REQ-003 SHALL provide parameter WAIT_TICKS, default 25_000_000, display hold time in clock cycles (>=1).
REQ-004 SHALL provide parameter LED_WIDTH, default 8, width of led (1..32).
REQ-005 SHALL provide parameter MODE, default 0, 0 = read-display only, 1 = write pattern then read-verify.
REQ-006 SHALL provide parameter SEED, default 32'h0000_0001, base of the write pattern.
REQ-007 SHALL provide parameter LOOP, default 1, 1 = restart automatically after each pass, 0 = stop after one pass.
REQ-008 clk  in  1  sole clock, all logic on posedge.
REQ-009 reset  in  1  synchronous, active-high.
REQ-010 start  in  1  begins a pass when sampled high in IDLE.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 done  out  1  one-cycle pulse at end of each pass.
REQ-013 error  out  1  sticky compare-mismatch flag (MODE=1 only).
REQ-014 err_addr  out  32  address of first mismatch.
REQ-015 led  out  LED_WIDTH  rdata[LED_WIDTH-1:0] of the last completed read.
REQ-016 mem_valid, mem_addr[31:0], mem_wdata[31:0], mem_wstrb[3:0]  out  request to bram_controller.
REQ-017 mem_ready  in  1, mem_rdata  in  32  response from bram_controller.

Function
REQ-018 SHALL implement FSM states IDLE, WRITE, READ, SHOW, and NEXT.
REQ-019 IDLE: on start=1, SHALL clear index to 0, clear error, and go to WRITE (MODE=1) or READ (MODE=0); start outside IDLE is ignored.
REQ-020 Word i SHALL use mem_addr = BASE_ADDR + 4*i, with 32-bit wrap.
REQ-021 WRITE: SHALL drive mem_wstrb=4'b1111 and mem_wdata=SEED+i (mod 2^32); on mem_ready, i increments; after word NUM_WORDS-1, i resets to 0 and the FSM goes to READ.
REQ-022 READ: SHALL drive mem_wstrb=4'b0000; on mem_ready, SHALL register mem_rdata[LED_WIDTH-1:0] into led on the same edge and go to SHOW.
REQ-023 MODE=1: in the mem_ready cycle of a read, mem_rdata != SEED+i SHALL set error; err_addr captures that address only if error was previously 0.
REQ-024 SHOW: SHALL hold for exactly WAIT_TICKS cycles (counter 0..WAIT_TICKS-1), then go to NEXT.
REQ-025 NEXT (1 cycle): if i < NUM_WORDS-1, SHALL increment i and go to READ; else SHALL pulse done and go to IDLE (LOOP=0) or restart at i=0 in WRITE/READ per MODE (LOOP=1) without requiring start.
REQ-026 Handshake: mem_valid, mem_addr, mem_wdata, and mem_wstrb SHALL be registered and held stable from assertion until the cycle mem_ready is sampled high.
REQ-027 mem_valid SHALL drop on the edge after mem_ready and stay low for at least 1 cycle before the next request.
REQ-028 mem_ready while mem_valid=0 SHALL be ignored; mem_rdata SHALL be sampled only when mem_valid & mem_ready.
REQ-029 mem_wdata SHALL be 0 during reads; no outputs SHALL carry X.
REQ-030 Index and tick counters SHALL be clog2-sized and never exceed NUM_WORDS-1 and WAIT_TICKS-1 respectively.
REQ-031 error and err_addr SHALL persist across done and LOOP restarts, and clear only on reset or start from IDLE.

Reset
REQ-032 When reset=1 at a clock edge, the block SHALL enter IDLE, with busy=0, done=0, error=0, err_addr=0, led=0, mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, and i=0.
REQ-033 Reset SHALL take priority over start and mem_ready in the same cycle.
REQ-034 Reset mid-transaction SHALL drop mem_valid on that edge; partially written BRAM contents are not restored.

Verification
REQ-035 MODE=0, NUM_WORDS=2, WAIT_TICKS=3, memory {0x81,0x42}, ready latency 1 -> led=0x81 then 0x42, each held 3 cycles in SHOW, done pulses once per pass, passes loop.
REQ-036 MODE=1, NUM_WORDS=4, SEED=0xA5, LOOP=0 -> writes 0xA5..0xA8 to 0x0,0x4,0x8,0xC, reads match, error=0, single done pulse, then IDLE with busy=0.
REQ-037 MODE=1, model corrupts the word at 0x8 on read -> error=1, err_addr=0x8; a second corruption at 0xC leaves err_addr=0x8.
REQ-038 mem_ready delayed 5 cycles -> mem_valid, mem_addr, and mem_wstrb stable for all 6 cycles, mem_valid low the next cycle, no double transaction.
REQ-039 reset asserted while mem_valid=1 in WRITE -> next cycle all outputs at reset values, and start then begins a fresh pass at i=0.
REQ-040 start pulsed during SHOW and mem_ready pulsed with mem_valid=0 -> no state or led change.
